mips_prog_loader: RTL

Hardware program loader for the MIPS pipeline's instruction ROM. It accepts a byte stream over a valid/ready interface and assembles big-endian 32-bit instruction words. Each completed word is written into sequential ROM addresses starting at 0. The loader holds the pipeline (`cpu_hold`) until a complete, word-aligned program has been written, then releases it so fetch starts at PC 0.

---
 rtl/mips_prog_loader.sv | 98 +++++++++
 1 files changed

// File: rtl/mips_prog_loader.sv
// Program loader for the MIPS instruction ROM: packs a big-endian byte stream
// into 32-bit words, writes them from address 0 upward and holds the CPU until done.
module mips_prog_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   input  logic              s_last,
   input  logic              reload,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [31:0]       rom_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [1:0] {LOAD, FLUSH, DONE, ERR} state_t;

   state_t          state;
   logic [1:0]      bidx;
   logic [ADDR_W:0] wr_ptr;
   logic [23:0]     sh;
   logic            accept;
   logic            full;

   assign s_ready    = (state == LOAD);
   assign accept     = s_valid && s_ready;
   assign full       = (wr_ptr == {1'b0, {ADDR_W{1'b1}}});
   assign word_count = wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         bidx      <= '0;
         wr_ptr    <= '0;
         sh        <= '0;
         rom_we    <= 1'b0;
         rom_addr  <= '0;
         rom_wdata <= '0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         rom_we <= 1'b0;
         unique case (state)
            LOAD: begin
               if (accept) begin
                  if (bidx == 2'd3) begin
                     // First three bytes sit in sh; the current byte completes the word
                     rom_we    <= 1'b1;
                     rom_addr  <= wr_ptr[ADDR_W-1:0];
                     rom_wdata <= {sh, s_data};
                     wr_ptr    <= wr_ptr + 1'b1;
                     bidx      <= '0;
                     if (s_last) begin
                        state <= FLUSH;
                     end else if (full) begin
                        state <= ERR;
                        err   <= 1'b1;
                     end
                  end else begin
                     sh <= {sh[15:0], s_data};
                     if (s_last) begin
                        state <= ERR;
                        err   <= 1'b1;
                        bidx  <= '0;
                     end else begin
                        bidx <= bidx + 1'b1;
                     end
                  end
               end
            end
            FLUSH: begin
               // Release only after the final ROM write cycle has completed
               state    <= DONE;
               done     <= 1'b1;
               cpu_hold <= 1'b0;
            end
            DONE, ERR: begin
               if (reload) begin
                  state    <= LOAD;
                  wr_ptr   <= '0;
                  bidx     <= '0;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  cpu_hold <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
